// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep for a small combinational gate netlist.
// Walks every input vector k = 0..V-1 on dut_in, holds each one for
// SETTLE_CYCLES+2 cycles, samples dut_out on the last edge of that window,
// rebuilds the observed truth table and compares it against a latched
// expected table. Bit V-1-k of either table belongs to vector k, so the
// MSB of a hex word such as 0x616A is the response to input 0.
module tt_sweep_checker #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   tt_expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   first_fail_valid,
  output logic [N_IN-1:0]        first_fail_idx,
  output logic [(1<<N_IN)-1:0]   captured_tt
);

  localparam int              V         = 1 << N_IN;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_K    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] ONE_K     = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

  state_t          state;
  logic [3:0]      hold_cnt;
  logic [V-1:0]    exp_tt;
  logic [N_IN-1:0] tt_pos;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Table bit position that belongs to vector k (V-1-k, i.e. MSB first).
  function automatic logic [N_IN-1:0] tt_bit_pos(input logic [N_IN-1:0] k);
    return LAST_K - k;
  endfunction

  // Compare the live gate output against the latched expectation for the current vector.
  always_comb begin
    tt_pos   = tt_bit_pos(dut_in);
    mismatch = (dut_out != exp_tt[tt_pos]);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  // Sweep sequencer: vector stepping, settle timing, capture and result bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      captured_tt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_tt           <= tt_expected;
            dut_in           <= '0;
            captured_tt      <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            hold_cnt         <= SETTLE_LD;
            state            <= HOLD;
          end
        end
        HOLD: begin
          // The cycle in which the counter reads zero is the last hold cycle,
          // so a zero settle time still gives one hold cycle.
          if (hold_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          captured_tt[tt_pos] <= dut_out;
          err_count           <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= dut_in;
          end
          if (dut_in == LAST_K) begin
            // dut_in deliberately stays at the last vector after the sweep.
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            dut_in   <= dut_in + ONE_K;
            hold_cnt <= SETTLE_LD;
            state    <= HOLD;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
